// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain controller.
// Holds the default widths, the FIFO geometry, the drain FSM state type and
// a helper that decides whether the output buffer can absorb one more read.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_LEN_W   = 5;

    // The FIFO has 16 storage slots but reports full at 15 entries.
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned FIFO_USABLE = FIFO_DEPTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    // Words already owed to the 2-entry buffer (held + in flight), minus the
    // one leaving this cycle, must stay below 2 for a new read to be safe.
    function automatic logic room_for_read(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       popping);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, popping};
        return pending < 3'd2;
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// 2-entry valid/ready output buffer for the drain controller.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/in_data  word captured from the FIFO this edge
//   out_valid/out_ready/out_data  downstream stream head (registered storage)
//   occ             number of words currently held (0..2)
// A capture and a transfer in the same cycle leave occupancy unchanged and
// preserve word order. A capture into a full buffer that is not draining is
// dropped; the controller never issues one.
module drain_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              push;
    logic              pop;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occ       = occ_q;

    assign pop  = out_valid & out_ready;
    assign push = in_valid & ((occ_q != 2'd2) | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Read-side drain controller for the 16-entry synchronous FIFO.
// On an accepted start it reads len words out of the FIFO and streams them
// on a valid/ready interface with a last marker, then pulses done.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, len        burst launch pulse and length (sampled when idle)
//   busy, done        burst in progress / one-cycle completion pulse
//   fifo_rd           read strobe to the FIFO (combinational)
//   fifo_dout         FIFO read data, valid the cycle after an accepted read
//   fifo_empty/full   FIFO status flags
//   fifo_wr           copy of the FIFO write strobe; a write beats a read
//   m_valid/m_ready/m_data/m_last  output stream
//   rd_count          words accepted downstream in the current/last burst
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_wr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [LEN_W-1:0]  rd_count
);

    drain_state_t     state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] rd_count_q, rd_count_d;
    logic             inflight_q, inflight_d;

    logic [1:0]       buf_occ;
    logic             xfer;
    logic             rd_acc;
    logic             write_wins;
    logic [LEN_W:0]   head_num;

    drain_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   (fifo_dout),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .occ       (buf_occ)
    );

    assign xfer = m_valid & m_ready;

    // A word leaving the buffer this cycle frees a slot for a read issued now,
    // which is what sustains one word per cycle with m_ready held high.
    assign fifo_rd = (state_q == RUN) && (remaining_q != '0) && !fifo_empty &&
                     room_for_read(buf_occ, inflight_q, xfer);

    // The FIFO drops our read when it services a write in the same cycle.
    assign write_wins = fifo_wr & ~fifo_full;
    assign rd_acc     = fifo_rd & ~fifo_empty & ~write_wins;

    // Head word is number rd_count+1 of the burst; one extra bit avoids wrap.
    assign head_num = {1'b0, rd_count_q} + (LEN_W + 1)'(1);
    assign m_last   = m_valid && (head_num == {1'b0, len_q});

    assign busy     = (state_q == RUN) || (state_q == FLUSH);
    assign done     = (state_q == DONE);
    assign rd_count = rd_count_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        rd_count_d  = rd_count_q;
        inflight_d  = rd_acc;

        if (rd_acc) begin
            remaining_d = remaining_q - LEN_W'(1);
        end
        if (xfer) begin
            rd_count_d = rd_count_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = len;
                    remaining_d = len;
                    rd_count_d  = '0;
                    state_d     = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && m_last) begin
                    state_d = DONE;
                end else if ((remaining_q == '0) && !inflight_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((xfer && m_last) || (buf_occ == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            remaining_q <= '0;
            rd_count_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            rd_count_q  <= rd_count_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a behavioural 16-entry FIFO attached.
// A negedge monitor scores every streamed word against write order and
// checks the buffering bound; the initial block drives directed steps.
module tb_fifo_drain;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       fifo_rd;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] wr_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [4:0] rd_count;
    logic       fclr;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_len  = 0;
    bit seen;
    logic [3:0] pat;

    always #5 clk = ~clk;

    fifo_drain u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .rd_count   (rd_count)
    );

    // Behavioural FIFO: write has priority over read, data one cycle late.
    logic [7:0]  fmem [FIFO_DEPTH];
    logic [3:0]  fwp = 4'd0;
    logic [3:0]  frp = 4'd0;
    int unsigned fcnt = 0;
    logic [7:0]  exp_mem [1024];
    int unsigned exp_wr = 0;
    int unsigned exp_rd = 0;

    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = (fcnt >= FIFO_USABLE);

    always @(posedge clk) begin
        if (fclr) begin
            frp  <= fwp;
            fcnt <= 0;
        end else if (fifo_wr && !fifo_full) begin
            fmem[fwp]       <= wr_data;
            fwp             <= fwp + 4'd1;
            fcnt            <= fcnt + 1;
            exp_mem[exp_wr] <= wr_data;
            exp_wr          <= exp_wr + 1;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= fmem[frp];
            frp       <= frp + 4'd1;
            fcnt      <= fcnt - 1;
        end
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Stream monitor: order, last marker, and at most 2 words owed downstream.
    int acc_n   = 0;
    int xfer_n  = 0;
    int burst_x = 0;
    int owed;

    always @(negedge clk) begin
        if (rst) begin
            acc_n   = 0;
            xfer_n  = 0;
            burst_x = 0;
            if (fclr) exp_rd = exp_wr;
        end else begin
            if (start && !busy && !done) burst_x = 0;
            owed = acc_n - xfer_n;
            chk_bit("owed_le_2", (owed <= 2), 1'b1);
            if (owed == 2 && !(m_valid && m_ready)) chk_bit("rd_blocked_full", fifo_rd, 1'b0);
            if (fifo_rd) chk_bit("rd_only_nonempty", fifo_empty, 1'b0);
            if (!m_valid) chk_bit("last_needs_valid", m_last, 1'b0);
            if (m_valid && m_ready) begin
                chk_val("stream_data", 32'(m_data), 32'(exp_mem[exp_rd]));
                chk_bit("stream_last", m_last, (burst_x + 1 == cur_len));
                exp_rd  = exp_rd + 1;
                burst_x = burst_x + 1;
                xfer_n  = xfer_n + 1;
            end
            if (done) begin
                chk_val("done_rd_count", 32'(rd_count), 32'(cur_len));
                chk_val("done_after_last", 32'(burst_x), 32'(cur_len));
            end
            if (fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full)) acc_n = acc_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] d);
        fifo_wr = 1'b1;
        wr_data = d;
        step();
        fifo_wr = 1'b0;
    endtask

    task automatic launch(input int n);
        cur_len = n;
        len     = 5'(n);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            at_neg();
            if (done) got = 1'b1;
            else step();
        end
        chk_bit(tag, got, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = 5'd0; fifo_wr = 1'b0; wr_data = 8'h00;
        m_ready = 1'b1; fclr = 1'b0; pat = 4'b1001;
        step();
        step();

        // 1: reset held against start
        start = 1'b1;
        len   = 5'd5;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk_bit("rst_busy", busy, 1'b0);
            chk_bit("rst_done", done, 1'b0);
            chk_bit("rst_valid", m_valid, 1'b0);
            chk_bit("rst_rd", fifo_rd, 1'b0);
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        at_neg();
        chk_bit("post_rst_busy", busy, 1'b0);
        chk_val("post_rst_count", 32'(rd_count), 32'd0);
        chk_val("post_rst_data", 32'(m_data), 32'd0);
        chk_bit("post_rst_last", m_last, 1'b0);
        step();

        // 2: full FIFO, 15-word burst at full rate
        for (int i = 0; i < 15; i++) push_word(8'($urandom_range(0, 255)));
        launch(15);
        at_neg();
        chk_bit("t2_first_rd", fifo_rd, 1'b1);
        chk_bit("t2_valid_c1", m_valid, 1'b0);
        chk_bit("t2_busy", busy, 1'b1);
        step();
        at_neg();
        chk_bit("t2_valid_c2", m_valid, 1'b0);
        step();
        for (int i = 0; i < 15; i++) begin
            at_neg();
            chk_bit("t2_back_to_back", m_valid, 1'b1);
            chk_bit("t2_last_pos", m_last, (i == 14));
            step();
        end
        at_neg();
        chk_bit("t2_done", done, 1'b1);
        chk_bit("t2_busy_low", busy, 1'b0);
        chk_val("t2_count", 32'(rd_count), 32'd15);
        chk_bit("t2_fifo_empty", fifo_empty, 1'b1);
        step();
        at_neg();
        chk_bit("t2_done_one_cycle", done, 1'b0);
        chk_val("t2_all_delivered", exp_rd, exp_wr);
        step();

        // 3: FIFO runs dry mid-burst, then refills
        for (int i = 0; i < 3; i++) push_word(8'(8'h30 + i));
        launch(5);
        repeat (8) step();
        at_neg();
        chk_val("t3_partial_count", 32'(rd_count), 32'd3);
        chk_bit("t3_still_busy", busy, 1'b1);
        chk_bit("t3_rd_idle", fifo_rd, 1'b0);
        chk_bit("t3_no_valid", m_valid, 1'b0);
        step();
        push_word(8'h40);
        push_word(8'h41);
        wait_done(20, "t3_done_seen");
        chk_val("t3_count", 32'(rd_count), 32'd5);
        step();
        chk_val("t3_all_delivered", exp_rd, exp_wr);

        // 4: downstream stalls with ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) push_word(8'(8'h50 + 3 * i));
        launch(8);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            m_ready = pat[i % 4];
            at_neg();
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk_bit("t4_done_seen", seen, 1'b1);
        chk_val("t4_count", 32'(rd_count), 32'd8);
        step();
        m_ready = 1'b1;
        chk_val("t4_all_delivered", exp_rd, exp_wr);

        // 5: a write collides with the first read and wins
        for (int i = 0; i < 6; i++) push_word(8'(8'h90 + i));
        launch(6);
        fifo_wr = 1'b1;
        wr_data = 8'hA5;
        at_neg();
        chk_bit("t5_rd_during_wr", fifo_rd, 1'b1);
        step();
        fifo_wr = 1'b0;
        at_neg();
        chk_bit("t5_rd_retried", fifo_rd, 1'b1);
        step();
        at_neg();
        chk_bit("t5_valid_delayed", m_valid, 1'b0);
        step();
        at_neg();
        chk_bit("t5_valid_after_retry", m_valid, 1'b1);
        step();
        wait_done(30, "t5_done_seen");
        chk_val("t5_count", 32'(rd_count), 32'd6);
        chk_val("t5_leftover", exp_wr - exp_rd, 32'd1);
        step();

        // 6a: zero-length burst completes without reading
        cur_len = 0;
        len     = 5'd0;
        start   = 1'b1;
        at_neg();
        chk_bit("t6_done_before", done, 1'b0);
        step();
        start = 1'b0;
        at_neg();
        chk_bit("t6_len0_done", done, 1'b1);
        chk_bit("t6_len0_busy", busy, 1'b0);
        chk_bit("t6_len0_no_rd", fifo_rd, 1'b0);
        step();
        at_neg();
        chk_bit("t6_len0_done_once", done, 1'b0);
        chk_bit("t6_len0_no_rd2", fifo_rd, 1'b0);
        chk_val("t6_len0_count", 32'(rd_count), 32'd0);
        step();

        // 6b: reset in the middle of a 10-word burst
        for (int i = 0; i < 10; i++) push_word(8'(8'hC0 + i));
        launch(10);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            at_neg();
            if (rd_count == 5'd4) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk_bit("t6_reached_4", seen, 1'b1);
        step();
        rst  = 1'b1;
        fclr = 1'b1;
        step();
        rst  = 1'b0;
        fclr = 1'b0;
        at_neg();
        chk_bit("t6_rst_busy", busy, 1'b0);
        chk_bit("t6_rst_done", done, 1'b0);
        chk_bit("t6_rst_rd", fifo_rd, 1'b0);
        chk_bit("t6_rst_valid", m_valid, 1'b0);
        chk_val("t6_rst_data", 32'(m_data), 32'd0);
        chk_bit("t6_rst_last", m_last, 1'b0);
        chk_val("t6_rst_count", 32'(rd_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            at_neg();
            chk_bit("t6_no_done_after_rst", done, 1'b0);
            chk_bit("t6_idle_after_rst", busy, 1'b0);
        end
        step();

        // Recovery burst after the mid-burst reset
        push_word(8'h11);
        push_word(8'h22);
        launch(2);
        wait_done(20, "t6_recover_done");
        chk_val("t6_recover_count", 32'(rd_count), 32'd2);
        step();
        chk_val("t6_recover_delivered", exp_rd, exp_wr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
